// File: rtl/verin_bus_arbiter.sv
// Round-robin arbiter and strobe sequencer for the actuator (verin) register bus.
// Two requesters (A = CPU register bridge, B = position poller) share one bus.
// Each access runs IDLE -> SETUP -> STROBE -> HOLD -> ACK -> IDLE with
// parameterised phase lengths. The strobe phase stretches while bus_wait is
// high and ends with a timeout once TIMEOUT_CYC strobe cycles have elapsed.
// Handshake: a requester raises req with we/addr/wdata stable and keeps req
// high until its one-cycle ack. req must be low in the cycle after the ack,
// otherwise the requester is granted again, still subject to round-robin.
// All outputs are registered. Each one is computed from the next state, so the
// output and the state take their new values on the same edge.
module verin_bus_arbiter #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 2,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        a_we,
  input  logic        b_we,
  input  logic [1:0]  a_addr,
  input  logic [1:0]  b_addr,
  input  logic [15:0] a_wdata,
  input  logic [15:0] b_wdata,
  output logic        a_ack,
  output logic        b_ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [1:0]  bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_oe,
  output logic        bus_write_n,
  output logic        bus_read_n,
  input  logic [15:0] bus_rdata,
  input  logic        bus_wait
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ACK
  } state_t;

  localparam logic [8:0] SETUP_L   = 9'(SETUP_CYC);
  localparam logic [8:0] STROBE_L  = 9'(STROBE_CYC);
  localparam logic [8:0] HOLD_L    = 9'(HOLD_CYC);
  localparam logic [8:0] TIMEOUT_L = 9'(TIMEOUT_CYC);

  state_t      state, state_nxt;
  logic [7:0]  cnt;          // cycles spent in the current state, minus one
  logic [8:0]  cnt_p1;       // cycles spent in the current state, this one included
  logic        last_grant;   // 1 = B was granted most recently
  logic        gnt_b;        // owner of the access in flight (1 = B)
  logic        op_we;        // direction of the access in flight
  logic        to_flag;      // access in flight timed out
  logic        grant;
  logic        sel_b;
  logic        we_nxt;
  logic        cap_ok;
  logic        to_hit;
  logic        drive_nxt;

  assign cnt_p1 = {1'b0, cnt} + 9'd1;

  // Arbitration, phase sequencing and decode of the next registered outputs.
  always_comb begin
    state_nxt = state;
    cap_ok    = 1'b0;
    to_hit    = 1'b0;
    grant     = 1'b0;
    // On a tie, grant the requester that was not granted last.
    sel_b     = b_req && (!a_req || !last_grant);
    case (state)
      S_IDLE: begin
        if (a_req || b_req) begin
          grant     = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_p1 >= SETUP_L) state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_p1 >= STROBE_L && !bus_wait) begin
          cap_ok    = 1'b1;
          state_nxt = S_HOLD;
        end else if (cnt_p1 >= TIMEOUT_L) begin
          to_hit    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_p1 >= HOLD_L) state_nxt = S_ACK;
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    we_nxt    = grant ? (sel_b ? b_we : a_we) : op_we;
    drive_nxt = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) ||
                (state_nxt == S_HOLD);
  end

  // State, phase counter, latched access and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      last_grant  <= 1'b1;
      gnt_b       <= 1'b0;
      op_we       <= 1'b0;
      to_flag     <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      rdata       <= 16'd0;
      bus_addr    <= 2'd0;
      bus_wdata   <= 16'd0;
      bus_oe      <= 1'b0;
      bus_write_n <= 1'b1;
      bus_read_n  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE) cnt <= 8'd0;
      else                                       cnt <= cnt + 8'd1;
      if (grant) begin
        gnt_b     <= sel_b;
        op_we     <= we_nxt;
        bus_addr  <= sel_b ? b_addr : a_addr;
        bus_wdata <= sel_b ? b_wdata : a_wdata;
        to_flag   <= 1'b0;
      end
      if (to_hit) to_flag <= 1'b1;
      if (cap_ok && !op_we) rdata <= bus_rdata;
      if (state == S_ACK) last_grant <= gnt_b;
      busy        <= (state_nxt != S_IDLE);
      bus_oe      <= drive_nxt && we_nxt;
      bus_write_n <= !((state_nxt == S_STROBE) && op_we);
      bus_read_n  <= !((state_nxt == S_STROBE) && !op_we);
      a_ack       <= (state_nxt == S_ACK) && !gnt_b;
      b_ack       <= (state_nxt == S_ACK) && gnt_b;
      err         <= (state_nxt == S_ACK) && to_flag;
    end
  end

endmodule
